// File: rtl/lap_store_ctrl_pkg.sv
// Shared types and constants for the stopwatch lap-memory controller.
package lap_store_ctrl_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    RECALL = 1'b1
  } lap_state_e;

  localparam int BCD_W = 4;

endpackage

// File: rtl/lap_store_ctrl_ram.sv
// Lap register file: one synchronous write port, one combinational read port, no reset on contents.
module lap_ram #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lap_store_ctrl.sv
// Stopwatch lap-memory controller: stores lap times and selects live or recalled display.
// Build option: define LAP_OVERWRITE_EN to overwrite the oldest lap when the buffer is full.
module lap_store_ctrl
  import lap_store_ctrl_pkg::*;
#(
  parameter  int DIGITS = 4,
  parameter  int DEPTH  = 8,
  localparam int W      = BCD_W * DIGITS,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lap_pulse,
  input  logic             clear,
  input  logic [W-1:0]     time_bcd,
  input  logic             recall_prev,
  input  logic             recall_next,
  input  logic             recall_exit,
  output logic [W-1:0]     disp_bcd,
  output logic             disp_is_lap,
  output logic [IDX_W-1:0] lap_index,
  output logic [CNT_W-1:0] lap_count,
  output logic             full,
  output logic             overflow
);

  lap_state_e       state, state_nxt;
  logic [IDX_W-1:0] wr_ptr, wr_nxt;
  logic [IDX_W-1:0] oldest_ptr, oldest_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             we;
  logic             is_full;
  logic [IDX_W-1:0] newest_idx;
  logic [IDX_W-1:0] raddr;
  logic [W-1:0]     rdata;
  logic [W-1:0]     disp_nxt;

  assign is_full    = (lap_count == CNT_W'(DEPTH));
  assign newest_idx = IDX_W'(lap_count - CNT_W'(1));

  always_comb begin
    state_nxt  = state;
    wr_nxt     = wr_ptr;
    oldest_nxt = oldest_ptr;
    idx_nxt    = lap_index;
    cnt_nxt    = lap_count;
    ovf_nxt    = overflow;
    we         = 1'b0;
    if (clear) begin
      state_nxt  = LIVE;
      wr_nxt     = '0;
      oldest_nxt = '0;
      idx_nxt    = '0;
      cnt_nxt    = '0;
      ovf_nxt    = 1'b0;
    end else if (lap_pulse) begin
      // Any lap, stored or dropped, returns the display to the live count.
      state_nxt = LIVE;
      idx_nxt   = '0;
      if (!is_full) begin
        we      = 1'b1;
        wr_nxt  = wr_ptr + IDX_W'(1);
        cnt_nxt = lap_count + CNT_W'(1);
      end else begin
        ovf_nxt = 1'b1;
`ifdef LAP_OVERWRITE_EN
        we         = 1'b1;
        wr_nxt     = wr_ptr + IDX_W'(1);
        oldest_nxt = wr_ptr + IDX_W'(1);
`endif
      end
    end else if (recall_exit) begin
      state_nxt = LIVE;
      idx_nxt   = '0;
    end else if (recall_prev ^ recall_next) begin
      if (state == LIVE) begin
        if (recall_prev && (lap_count != '0)) begin
          state_nxt = RECALL;
          idx_nxt   = newest_idx;
        end
      end else if (recall_prev) begin
        if (lap_index != '0) idx_nxt = lap_index - IDX_W'(1);
      end else if (lap_index != newest_idx) begin
        idx_nxt = lap_index + IDX_W'(1);
      end else begin
        state_nxt = LIVE;
        idx_nxt   = '0;
      end
    end
  end

  // Read with next-cycle pointers so the registered display tracks the new index at once.
  assign raddr    = oldest_nxt + idx_nxt;
  assign disp_nxt = (state_nxt == RECALL) ? rdata : time_bcd;

  lap_ram #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (time_bcd),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= LIVE;
      wr_ptr      <= '0;
      oldest_ptr  <= '0;
      lap_index   <= '0;
      lap_count   <= '0;
      overflow    <= 1'b0;
      full        <= 1'b0;
      disp_bcd    <= '0;
      disp_is_lap <= 1'b0;
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_nxt;
      oldest_ptr  <= oldest_nxt;
      lap_index   <= idx_nxt;
      lap_count   <= cnt_nxt;
      overflow    <= ovf_nxt;
      full        <= (cnt_nxt == CNT_W'(DEPTH));
      disp_bcd    <= disp_nxt;
      disp_is_lap <= (state_nxt == RECALL);
    end
  end

endmodule

// File: doc/lap_store_ctrl.md
# lap_store_ctrl

Lap-memory controller for the stopwatch. It captures the running BCD time into a small register buffer on every lap pulse from the stopwatch controller, and sequences what the display shows: the live count, or a stored lap selected with prev/next buttons. It sits between the time counter, the display driver and the debounced button pulses.

## Interface
- DIGITS, 4, number of BCD digits in the time word
- DEPTH, 8, number of lap entries (power of two, ≥2)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- lap_pulse  in  1  one-cycle request to store current time
- clear  in  1  level; empties buffer, returns to live view
- time_bcd  in  4*DIGITS  live counter value, BCD
- recall_prev  in  1  one-cycle pulse; enter recall / step to older lap
- recall_next  in  1  one-cycle pulse; step to newer lap / leave recall
- recall_exit  in  1  one-cycle pulse; return to live view
- disp_bcd  out  4*DIGITS  value for display driver
- disp_is_lap  out  1  1 while showing a stored lap
- lap_index  out  clog2(DEPTH)  logical index shown (0 = oldest)
- lap_count  out  clog2(DEPTH+1)  number of valid entries
- full  out  1  lap_count == DEPTH
- overflow  out  1  sticky; a lap was dropped or overwritten

## Operation
- States: LIVE, RECALL. Reset state is LIVE.
- Priority each cycle: clear > lap_pulse > recall_exit > recall_prev/recall_next.
- clear (any state): lap_count=0, write pointer=0, overflow=0, lap_index=0, go to LIVE.
- lap_pulse, not full: write time_bcd, as sampled in that cycle, at the write pointer. Pointer increments mod DEPTH. lap_count increments.
- lap_pulse, full: behaviour set by the Configuration macro. In both cases overflow is set to 1.
- lap_pulse in RECALL: the entry is stored as above and the state returns to LIVE.
- LIVE + recall_prev:
  - lap_count>0: go to RECALL with lap_index = lap_count-1 (newest).
  - lap_count=0: ignored.
- LIVE + recall_next or recall_exit: ignored.
- RECALL + recall_prev: lap_index decrements, saturating at 0.
- RECALL + recall_next: if lap_index < lap_count-1, lap_index increments. If lap_index is already the newest, go to LIVE.
- RECALL + recall_exit: go to LIVE.
- recall_prev and recall_next in the same cycle: both ignored.
- Physical slot = (oldest pointer + lap_index) mod DEPTH. The oldest pointer is 0 until the first overwrite, then equals the write pointer.
- In LIVE, lap_index holds 0.

## Timing
- All outputs are registered. Reset value of every output is 0.
- disp_bcd in LIVE: time_bcd delayed by 1 cycle.
- disp_bcd in RECALL: the stored entry at lap_index, valid 1 cycle after any state or index change.
- lap_count, full and overflow update in the cycle after the triggering pulse.
- A lap stored in cycle N can be recalled by a recall_prev in cycle N+1 and shows the new entry.
- Reset mid-operation clears all state immediately. Buffer contents need not be cleared; they are unreachable while lap_count=0.

## Configuration
- LAP_OVERWRITE_EN defined:
  - A lap on a full buffer overwrites the oldest entry.
  - Write and oldest pointers both advance; lap_count stays DEPTH.
  - In RECALL, a lap write exits to LIVE, so the display never shows a stale index.
- LAP_OVERWRITE_EN undefined:
  - A lap on a full buffer is dropped; buffer and pointers are unchanged.
  - If the drop occurs in RECALL, the state still returns to LIVE.
- overflow is set to 1 in both cases.

## Structure
- Shared package holds:
  - state encoding (LIVE=1'b0, RECALL=1'b1)
  - BCD digit width constant (4)
- Sub-module lap_ram: DEPTH × 4*DIGITS register file, one synchronous write port, one combinational read port. No reset on contents.
- The controller instantiates lap_ram and owns the pointers, count, FSM and output registers.

## Test plan
- Reset, then drive time_bcd=16'h0123.
  - Expect disp_bcd=16'h0123 one cycle later; disp_is_lap=0; lap_count=0.
- Laps at times 0001, 0002, 0003, then recall_prev ×2.
  - After the first recall_prev: disp 0003, lap_index=2.
  - After the second: disp 0002, lap_index=1.
  - recall_next ×2: second pulse returns to LIVE.
- Nine laps with DEPTH=8, values 0001..0009.
  - With macro: oldest recalled entry = 0002, newest = 0009, overflow=1.
  - Without macro: oldest = 0001, newest = 0008, overflow=1, full=1.
- clear, lap_pulse and recall_prev high in the same cycle, in RECALL.
  - Expect LIVE, lap_count=0, overflow=0.
- lap_pulse in RECALL at lap_index=0.
  - Expect entry stored, state LIVE one cycle later, lap_count+1.
- Assert rst mid-RECALL.
  - Expect all outputs 0 asynchronously, state LIVE.
  - A subsequent recall_prev is ignored (lap_count=0).
